// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: IDLE/SERVE/PLAY/POINT/OVER flow, movement tick generation,
// miss detection from the ball x position, score keeping and game-over detection.
module pong_game_ctrl #(
  parameter int TICK_DIV     = 65536,
  parameter int SERVE_CYCLES = 16,
  parameter int LEFT_MISS_X  = 90,
  parameter int RIGHT_MISS_X = 550,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic [9:0] ball_x_pos,
  output logic       tick,
  output logic       ball_load,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_e;

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_CYCLES - 1);
  localparam logic [9:0]    LEFT_X     = 10'(LEFT_MISS_X);
  localparam logic [9:0]    RIGHT_X    = 10'(RIGHT_MISS_X);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  state_e        state_q, state_d;
  logic          tick_q, tick_d;
  logic          load_q, load_d;
  logic          dir_q, dir_d;
  logic [3:0]    sl_q, sl_d;
  logic [3:0]    sr_q, sr_d;
  logic          go_q, go_d;
  logic          start_prev_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] serve_cnt_q, serve_cnt_d;
  logic          start_rise, left_miss, right_miss;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  assign start_rise = start & ~start_prev_q;
  assign left_miss  = (ball_x_pos <= LEFT_X);
  assign right_miss = (ball_x_pos >= RIGHT_X);

  always_comb begin
    state_d     = state_q;
    sl_d        = sl_q;
    sr_d        = sr_q;
    dir_d       = dir_q;
    tick_d      = 1'b0;
    tick_cnt_d  = tick_cnt_q;
    serve_cnt_d = serve_cnt_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          sl_d    = 4'd0;
          sr_d    = 4'd0;
          dir_d   = 1'b1;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (serve_cnt_q == SERVE_LAST) begin
          serve_cnt_d = '0;
          state_d     = PLAY;
        end else begin
          serve_cnt_d = serve_cnt_q + 1'b1;
        end
      end
      PLAY: begin
        // A miss leaves PLAY, so it takes priority over a tick that would land in POINT.
        if (!pause) begin
          if (left_miss) begin
            sr_d       = sat_inc(sr_q);
            dir_d      = 1'b0;
            state_d    = POINT;
            tick_cnt_d = '0;
          end else if (right_miss) begin
            sl_d       = sat_inc(sl_q);
            dir_d      = 1'b1;
            state_d    = POINT;
            tick_cnt_d = '0;
          end else if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      POINT: begin
        state_d = (sl_q == WIN || sr_q == WIN) ? OVER : SERVE;
      end
      default: state_d = IDLE;
    endcase
    load_d = (state_d == SERVE) && (state_q != SERVE);
    go_d   = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tick_q       <= 1'b0;
      load_q       <= 1'b0;
      dir_q        <= 1'b1;
      sl_q         <= 4'd0;
      sr_q         <= 4'd0;
      go_q         <= 1'b0;
      start_prev_q <= 1'b0;
      tick_cnt_q   <= '0;
      serve_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      load_q       <= load_d;
      dir_q        <= dir_d;
      sl_q         <= sl_d;
      sr_q         <= sr_d;
      go_q         <= go_d;
      start_prev_q <= start;
      tick_cnt_q   <= tick_cnt_d;
      serve_cnt_q  <= serve_cnt_d;
    end
  end

  assign state       = state_q;
  assign tick        = tick_q;
  assign ball_load   = load_q;
  assign serve_dir   = dir_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign game_over   = go_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl against a game-rule reference model.
module tb_pong_game_ctrl;
  localparam int TD = 4;
  localparam int SC = 8;
  localparam int WS = 3;
  localparam int LX = 90;
  localparam int RX = 550;

  logic       clk = 1'b0;
  logic       reset_n, start, pause;
  logic [9:0] bx;
  logic       tick, ball_load, serve_dir, game_over;
  logic [3:0] score_left, score_right;
  logic [2:0] state;
  logic [14:0] obs;

  int checks = 0;
  int passes = 0;

  // Reference model: game rules expressed as elapsed-cycle and phase counters.
  int   m_state, m_sl, m_sr, m_elapsed, m_phase;
  logic m_dir, m_tick, m_load, m_prev;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .TICK_DIV(TD), .SERVE_CYCLES(SC), .LEFT_MISS_X(LX), .RIGHT_MISS_X(RX), .WIN_SCORE(WS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .ball_x_pos(bx),
    .tick(tick), .ball_load(ball_load), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right), .state(state), .game_over(game_over)
  );

  assign obs = {state, tick, ball_load, serve_dir, score_left, score_right, game_over};

  function automatic logic [14:0] exp_vec();
    return {3'(m_state), m_tick, m_load, m_dir, 4'(m_sl), 4'(m_sr), (m_state == 4)};
  endfunction

  function automatic logic [9:0] mid_x();
    return 10'($urandom_range(RX - 1, LX + 1));
  endfunction

  task automatic model_reset();
    m_state = 0; m_sl = 0; m_sr = 0; m_elapsed = 0; m_phase = 0;
    m_dir = 1'b1; m_tick = 1'b0; m_load = 1'b0; m_prev = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic [9:0] x);
    logic rise;
    rise   = s && !m_prev;
    m_prev = s;
    m_tick = 1'b0;
    m_load = 1'b0;
    case (m_state)
      0, 4: if (rise) begin
        m_sl = 0; m_sr = 0; m_dir = 1'b1; m_state = 1; m_elapsed = 0; m_load = 1'b1;
      end
      1: begin
        m_elapsed++;
        if (m_elapsed == SC) begin m_state = 2; m_phase = 0; end
      end
      2: if (!p) begin
        if (int'(x) <= LX) begin
          m_sr = (m_sr < WS) ? m_sr + 1 : WS; m_dir = 1'b0; m_state = 3;
        end else if (int'(x) >= RX) begin
          m_sl = (m_sl < WS) ? m_sl + 1 : WS; m_dir = 1'b1; m_state = 3;
        end else begin
          m_phase++;
          if (m_phase == TD) begin m_phase = 0; m_tick = 1'b1; end
        end
      end
      3: if (m_sl == WS || m_sr == WS) m_state = 4;
         else begin m_state = 1; m_elapsed = 0; m_load = 1'b1; end
      default: m_state = 0;
    endcase
  endtask

  task automatic cycle(input logic s, input logic p, input logic [9:0] x);
    start = s; pause = p; bx = x;
    @(posedge clk);
    model_step(s, p, x);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; bx = 10'd300;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_vec()) $display("FAIL reset_values got=%h exp=%h", obs, exp_vec());
    else passes++;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, mid_x());
      checks++;
      if (obs !== exp_vec()) $display("FAIL idle_hold c%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
  endtask

  task automatic test_serve_play();
    cycle(1'b1, 1'b0, 10'd300);
    checks++;
    if (state !== 3'd1 || ball_load !== 1'b1)
      $display("FAIL serve_entry got state=%0d load=%b exp state=1 load=1", state, ball_load);
    else passes++;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0, mid_x());
      checks++;
      if (obs !== exp_vec()) $display("FAIL serve_play c%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 72; i++) begin
      logic p;
      if (i < 2) p = 1'b0;
      else if (i < 12) p = 1'b1;
      else if (i < 32) p = 1'b0;
      else p = 1'($urandom_range(1, 0));
      cycle(1'b0, p, mid_x());
      checks++;
      if (obs !== exp_vec()) $display("FAIL pause c%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
  endtask

  task automatic serve_to_play(input string name);
    for (int i = 0; i < 40 && m_state != 2; i++) begin
      cycle(1'b0, 1'b0, mid_x());
      checks++;
      if (obs !== exp_vec()) $display("FAIL %s c%0d got=%h exp=%h", name, i, obs, exp_vec());
      else passes++;
    end
    checks++;
    if (state !== 3'd2) $display("FAIL %s_reach_play got state=%0d exp=2", name, state);
    else passes++;
  endtask

  task automatic test_miss();
    cycle(1'b0, 1'b0, 10'd90);
    checks++;
    if (state !== 3'd3 || score_right !== 4'd1 || serve_dir !== 1'b0)
      $display("FAIL left_miss got st=%0d sr=%0d dir=%b exp st=3 sr=1 dir=0", state, score_right, serve_dir);
    else passes++;
    cycle(1'b0, 1'b0, mid_x());
    checks++;
    if (state !== 3'd1 || ball_load !== 1'b1)
      $display("FAIL left_reserve got st=%0d load=%b exp st=1 load=1", state, ball_load);
    else passes++;
    serve_to_play("left_serve");
    cycle(1'b0, 1'b0, 10'd550);
    checks++;
    if (obs !== exp_vec() || score_left !== 4'd1 || serve_dir !== 1'b1)
      $display("FAIL right_miss got=%h exp=%h", obs, exp_vec());
    else passes++;
    cycle(1'b0, 1'b0, mid_x());
    serve_to_play("right_serve");
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 200 && m_state != 4; i++) begin
      cycle(1'b0, 1'b0, (m_state == 2) ? 10'd550 : mid_x());
      checks++;
      if (obs !== exp_vec()) $display("FAIL to_over c%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
    checks++;
    if (state !== 3'd4 || game_over !== 1'b1 || score_left !== 4'd3)
      $display("FAIL over_state got st=%0d go=%b sl=%0d exp st=4 go=1 sl=3", state, game_over, score_left);
    else passes++;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 10'd550);
      checks++;
      if (obs !== exp_vec()) $display("FAIL over_hold c%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
    cycle(1'b1, 1'b0, mid_x());
    checks++;
    if (state !== 3'd1 || score_left !== 4'd0 || score_right !== 4'd0 || serve_dir !== 1'b1)
      $display("FAIL restart got st=%0d sl=%0d sr=%0d dir=%b exp 1/0/0/1", state, score_left, score_right, serve_dir);
    else passes++;
    serve_to_play("restart_serve");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      logic s, p;
      logic [9:0] x;
      int r;
      s = ($urandom_range(19, 0) == 0);
      p = ($urandom_range(7, 0) == 0);
      r = $urandom_range(59, 0);
      if (r == 0) x = 10'($urandom_range(LX, 0));
      else if (r == 1) x = 10'($urandom_range(1023, RX));
      else x = mid_x();
      cycle(s, p, x);
      checks++;
      if (obs !== exp_vec()) $display("FAIL random c%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
  endtask

  task automatic test_reset_midgame();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    cycle(1'b1, 1'b0, mid_x());
    serve_to_play("mg_serve0");
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 10'd550);
      cycle(1'b0, 1'b0, mid_x());
      serve_to_play("mg_serve");
    end
    for (int i = 0; i < 10 && m_phase != 2; i++) cycle(1'b0, 1'b0, mid_x());
    checks++;
    if (obs !== exp_vec() || score_left !== 4'd2)
      $display("FAIL mg_setup got=%h exp=%h", obs, exp_vec());
    else passes++;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_vec()) $display("FAIL async_reset got=%h exp=%h", obs, exp_vec());
    else passes++;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, mid_x());
      checks++;
      if (obs !== exp_vec()) $display("FAIL post_reset c%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
    cycle(1'b1, 1'b0, mid_x());
    for (int i = 0; i < SC + TD + 2; i++) begin
      cycle(1'b0, 1'b0, mid_x());
      checks++;
      if (obs !== exp_vec()) $display("FAIL post_reset_serve c%0d got=%h exp=%h", i, obs, exp_vec());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_serve_play();
    test_pause();
    test_miss();
    test_game_over();
    test_random();
    test_reset_midgame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the pong datapath. It owns the IDLE/SERVE/PLAY/POINT/OVER flow and generates the single-cycle movement tick that drives the ball and paddle position registers, replacing any derived/ripple clock. It also detects missed balls from the ball x position, keeps both scores, re-serves the ball, and declares game over.

Parameters:
TICK_DIV, 65536, clk cycles per movement tick in PLAY (≥2)
SERVE_CYCLES, 16, clk cycles spent in SERVE before PLAY (≥1)
LEFT_MISS_X, 90, ball_x_pos ≤ this is a left-side miss (right player scores)
RIGHT_MISS_X, 550, ball_x_pos ≥ this is a right-side miss (left player scores)
WIN_SCORE, 9, score that ends the game (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  start/restart button level, synchronous to clk
pause  in  1  level; freezes play while high
ball_x_pos  in  10  current ball x from ball datapath
tick  out  1  one-cycle move enable for ball/paddle registers
ball_load  out  1  one-cycle pulse: ball datapath reloads serve position
serve_dir  out  1  initial x direction for the loaded ball, 1 = rightward
score_left  out  4  left player score
score_right  out  4  right player score
state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
game_over  out  1  high while in OVER

Behaviour:
- Reset: clk and reset_n only, asynchronous active-low. Values: state=IDLE, tick=0, ball_load=0, serve_dir=1, scores=0, game_over=0, all counters 0, start_d=0.
- Start edge: start_rise = start & ~start_d. start_d is registered every cycle. It is used only in IDLE and OVER and ignored in all other states.
- All outputs are registered.
- IDLE: on start_rise, next state=SERVE, scores cleared to 0, serve_dir=1.
- SERVE:
  - ball_load=1 for exactly the first cycle in SERVE and 0 otherwise.
  - serve_cnt counts 0..SERVE_CYCLES-1. When it reaches SERVE_CYCLES-1, next state=PLAY and serve_cnt clears.
  - SERVE therefore lasts exactly SERVE_CYCLES cycles.
  - pause has no effect in SERVE.
- PLAY tick generation:
  - tick_cnt increments every cycle in PLAY while pause=0.
  - When tick_cnt==TICK_DIV-1, tick=1 in the following cycle and tick_cnt wraps to 0. Ticks are spaced exactly TICK_DIV cycles apart.
  - While pause=1, tick_cnt holds and tick=0. Resuming continues from the held count.
  - tick_cnt clears to 0 on any exit from PLAY. tick is never 1 outside PLAY.
- PLAY miss detection:
  - Checked every cycle while pause=0.
  - ball_x_pos ≤ LEFT_MISS_X: score_right+1, serve_dir=0 (serve toward the conceding left player), next state=POINT.
  - ball_x_pos ≥ RIGHT_MISS_X: score_left+1, serve_dir=1, next state=POINT.
  - If both conditions are true (misconfiguration), the left-side miss wins and exactly one score increments.
  - The comparison is 10-bit unsigned. A ball_x_pos that underflowed to a large value counts as a right-side miss; this is documented, not corrected.
- POINT: exactly one cycle. If score_left==WIN_SCORE or score_right==WIN_SCORE, next state=OVER; otherwise next state=SERVE.
- OVER:
  - game_over=1, tick=0, scores held.
  - On start_rise: scores cleared, serve_dir=1, next state=SERVE.
- Scores never exceed WIN_SCORE. Increments happen only on the PLAY→POINT transition.
- Reset mid-game (any state) returns immediately to the reset values listed above. No pending ball_load or tick survives reset.

Test Plan:
1. Params TICK_DIV=4, SERVE_CYCLES=8, WIN_SCORE=3; release reset, hold start=0 for 20 cycles -> state=0, tick never 1, scores 0.
2. Pulse start 1 cycle, hold ball_x_pos=300 -> next cycle state=1 with ball_load=1 for that cycle only; state=2 after 8 SERVE cycles; tick pulses exactly every 4 cycles.
3. In PLAY, assert pause for 10 cycles mid-count -> no tick during pause; after release the next tick arrives in the remaining count (4 minus the count held at pause).
4. In PLAY, drive ball_x_pos=90 -> score_right=1, serve_dir=0, state=3 for one cycle, then state=1 with ball_load=1. Repeat with ball_x_pos=550 -> score_left=1, serve_dir=1.
5. Drive 3 right-side misses -> score_left=3, state=4, game_over=1. Hold ball_x_pos=550 -> no further increments. Raise start -> scores 0, state=1, serve_dir=1.
6. Assert reset_n=0 in PLAY with score_left=2 and tick_cnt=2 -> asynchronously state=0, scores 0, tick=0, ball_load=0. After release, the first tick occurs only after a new start and full serve.
